// File: rtl/cphy_rx_pkg.sv
// rtl/cphy_rx_pkg.sv - shared states, LP vectors and decode helpers for the C-PHY LP control receiver
package cphy_rx_pkg;

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_HS_RQST   = 3'd1,
    ST_HS_ACTIVE = 3'd2,
    ST_LP_RQST   = 3'd3,
    ST_LP_YIELD  = 3'd4,
    ST_TA_RQST   = 3'd5,
    ST_ERR       = 3'd6
  } lane_state_e;

  // LP vectors are {A,B,C}
  localparam logic [2:0] LP_STOP   = 3'b111;
  localparam logic [2:0] LP_HSRQ   = 3'b001;
  localparam logic [2:0] LP_BRIDGE = 3'b000;
  localparam logic [2:0] LP_LPRQ   = 3'b100;

  localparam logic [1:0] CODE_STOP   = 2'b00;
  localparam logic [1:0] CODE_HSRQ   = 2'b01;
  localparam logic [1:0] CODE_BRIDGE = 2'b10;
  localparam logic [1:0] CODE_LPRQ   = 2'b11;

  localparam int PULSE_HS_ENTRY  = 0;
  localparam int PULSE_HS_EXIT   = 1;
  localparam int PULSE_LP_ENTRY  = 2;
  localparam int PULSE_TA_RQST   = 3;
  localparam int PULSE_SEQ_ERROR = 4;
  localparam int PULSE_W         = 5;

  function automatic logic lp_is_valid(input logic [2:0] lp);
    logic ok;
    ok = (lp == LP_STOP) || (lp == LP_HSRQ) || (lp == LP_BRIDGE) || (lp == LP_LPRQ);
    return ok;
  endfunction

  function automatic logic [1:0] lp_to_code(input logic [2:0] lp);
    logic [1:0] code;
    case (lp)
      LP_HSRQ:   code = CODE_HSRQ;
      LP_BRIDGE: code = CODE_BRIDGE;
      LP_LPRQ:   code = CODE_LPRQ;
      default:   code = CODE_STOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rx_ctrl_lane_fsm.sv
// rtl/rx_ctrl_lane_fsm.sv - one trio: LP glitch filter, control-code decode and entry-sequence FSM
module rx_ctrl_lane_fsm
  import cphy_rx_pkg::*;
#(
  parameter int FILTER_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] lp_i,
  output logic [1:0] code_o,
  output logic       code_valid_o,
  output logic [2:0] state_o,
  output logic       hs_entry_o,
  output logic       hs_exit_o,
  output logic       lp_entry_o,
  output logic       ta_rqst_o,
  output logic       seq_error_o
);

  localparam int CNT_W = $clog2(FILTER_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_DEPTH - 1);

  logic [2:0]         raw_q, raw_d;
  logic [2:0]         filt_q, filt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         code_q, code_d;
  logic               filt_chg_q, filt_chg_d;
  lane_state_e        state_q, state_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;

  // Accept only when the input also still matches raw_q, so a run of exactly
  // FILTER_DEPTH cycles is rejected and FILTER_DEPTH+1 is the shortest accepted.
  always_comb begin
    raw_d      = lp_i;
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    code_d     = code_q;
    filt_chg_d = 1'b0;
    if (lp_i != raw_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((lp_i == raw_q) && (cnt_q == CNT_MAX) && (raw_q != filt_q)) begin
      filt_d     = raw_q;
      filt_chg_d = 1'b1;
      if (lp_is_valid(raw_q)) begin
        code_d = lp_to_code(raw_q);
      end
    end
    if (!en_i) begin
      raw_d      = LP_STOP;
      cnt_d      = '0;
      filt_d     = LP_STOP;
      code_d     = CODE_STOP;
      filt_chg_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q      <= LP_STOP;
      filt_q     <= LP_STOP;
      cnt_q      <= '0;
      code_q     <= CODE_STOP;
      filt_chg_q <= 1'b0;
    end else begin
      raw_q      <= raw_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      filt_chg_q <= filt_chg_d;
    end
  end

  // FSM steps only in the cycle after the filtered vector changed
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    if (filt_chg_q) begin
      case (state_q)
        ST_STOP: begin
          if (filt_q == LP_HSRQ)      state_d = ST_HS_RQST;
          else if (filt_q == LP_LPRQ) state_d = ST_LP_RQST;
          else                        state_d = ST_ERR;
        end
        ST_HS_RQST: begin
          if (filt_q == LP_BRIDGE) begin
            state_d                 = ST_HS_ACTIVE;
            pulse_d[PULSE_HS_ENTRY] = 1'b1;
          end else if (filt_q == LP_STOP) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_HS_ACTIVE: begin
          if (filt_q == LP_STOP) begin
            state_d                = ST_STOP;
            pulse_d[PULSE_HS_EXIT] = 1'b1;
          end
        end
        ST_LP_RQST: begin
          if (filt_q == LP_BRIDGE) begin
            state_d                 = ST_LP_YIELD;
            pulse_d[PULSE_LP_ENTRY] = 1'b1;
          end else if (filt_q == LP_STOP) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_LP_YIELD: begin
          if (filt_q == LP_LPRQ) begin
            state_d                = ST_TA_RQST;
            pulse_d[PULSE_TA_RQST] = 1'b1;
          end else if (filt_q == LP_STOP) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_TA_RQST: begin
          if (filt_q == LP_BRIDGE)    state_d = ST_TA_RQST;
          else if (filt_q == LP_STOP) state_d = ST_STOP;
          else                        state_d = ST_ERR;
        end
        ST_ERR: begin
          if (filt_q == LP_STOP) state_d = ST_STOP;
        end
        default: state_d = ST_ERR;
      endcase
      if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
        pulse_d[PULSE_SEQ_ERROR] = 1'b1;
      end
    end
    if (!en_i) begin
      state_d = ST_STOP;
      pulse_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STOP;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = lp_is_valid(filt_q);
  assign state_o      = state_q;
  assign hs_entry_o   = pulse_q[PULSE_HS_ENTRY];
  assign hs_exit_o    = pulse_q[PULSE_HS_EXIT];
  assign lp_entry_o   = pulse_q[PULSE_LP_ENTRY];
  assign ta_rqst_o    = pulse_q[PULSE_TA_RQST];
  assign seq_error_o  = pulse_q[PULSE_SEQ_ERROR];

endmodule

// File: rtl/rx_ctrl_seq_detector.sv
// rtl/rx_ctrl_seq_detector.sv - multi-trio C-PHY LP control-sequence receiver top
module rx_ctrl_seq_detector
  import cphy_rx_pkg::*;
#(
  parameter int NUM_LANES    = 3,
  parameter int FILTER_DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   CtrlDecoderEn,
  input  logic [NUM_LANES-1:0]   LpA,
  input  logic [NUM_LANES-1:0]   LpB,
  input  logic [NUM_LANES-1:0]   LpC,
  output logic [2*NUM_LANES-1:0] CtrlDecoderOut,
  output logic [NUM_LANES-1:0]   CtrlCodeValid,
  output logic [3*NUM_LANES-1:0] LaneState,
  output logic [NUM_LANES-1:0]   HsEntry,
  output logic [NUM_LANES-1:0]   HsExit,
  output logic [NUM_LANES-1:0]   LpEntry,
  output logic [NUM_LANES-1:0]   TaRqst,
  output logic [NUM_LANES-1:0]   SeqError
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_ctrl_lane_fsm #(
      .FILTER_DEPTH (FILTER_DEPTH)
    ) u_lane (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .en_i         (CtrlDecoderEn),
      .lp_i         ({LpA[g], LpB[g], LpC[g]}),
      .code_o       (CtrlDecoderOut[2*g +: 2]),
      .code_valid_o (CtrlCodeValid[g]),
      .state_o      (LaneState[3*g +: 3]),
      .hs_entry_o   (HsEntry[g]),
      .hs_exit_o    (HsExit[g]),
      .lp_entry_o   (LpEntry[g]),
      .ta_rqst_o    (TaRqst[g]),
      .seq_error_o  (SeqError[g])
    );
  end

endmodule

// File: tb/tb_rx_ctrl_seq_detector.sv
// tb/tb_rx_ctrl_seq_detector.sv - scoreboard bench with a run-length/transition-table reference model
module tb_rx_ctrl_seq_detector;

  localparam int N = 3;
  localparam int D = 4;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           CtrlDecoderEn = 1'b1;
  logic [N-1:0]   LpA = '1, LpB = '1, LpC = '1;
  logic [2*N-1:0] CtrlDecoderOut;
  logic [N-1:0]   CtrlCodeValid;
  logic [3*N-1:0] LaneState;
  logic [N-1:0]   HsEntry, HsExit, LpEntry, TaRqst, SeqError;

  rx_ctrl_seq_detector #(.NUM_LANES(N), .FILTER_DEPTH(D)) dut (
    .Clk(Clk), .Rst(Rst), .CtrlDecoderEn(CtrlDecoderEn),
    .LpA(LpA), .LpB(LpB), .LpC(LpC),
    .CtrlDecoderOut(CtrlDecoderOut), .CtrlCodeValid(CtrlCodeValid), .LaneState(LaneState),
    .HsEntry(HsEntry), .HsExit(HsExit), .LpEntry(LpEntry), .TaRqst(TaRqst), .SeqError(SeqError)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2*N-1:0] code;
    logic [N-1:0]   valid;
    logic [3*N-1:0] state;
    logic [N-1:0]   hse, hsx, lpe, ta, err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  // Reference model: accepted state = value seen on D+1 consecutive cycles,
  // FSM = lookup table of (state, vector) -> next state, pulses from the pair.
  int         nxt_tbl[7][8];
  logic [2:0] run_val[N];
  int         run_len[N];
  logic [2:0] m_filt[N];
  logic [1:0] m_code[N];
  int         m_state[N];
  bit         m_pend[N];

  function automatic bit is_valid(input logic [2:0] v);
    return (v == 3'b111) || (v == 3'b001) || (v == 3'b000) || (v == 3'b100);
  endfunction

  function automatic logic [1:0] code_of(input logic [2:0] v);
    logic [1:0] c;
    c = 2'b00;
    if (v == 3'b001) c = 2'b01;
    if (v == 3'b000) c = 2'b10;
    if (v == 3'b100) c = 2'b11;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, got, exp);
  endtask

  task automatic model_init();
    for (int s = 0; s < 7; s++)
      for (int v = 0; v < 8; v++)
        nxt_tbl[s][v] = (s == 2) ? 2 : 6;
    for (int s = 1; s < 7; s++) nxt_tbl[s][7] = 0;
    nxt_tbl[0][1] = 1;
    nxt_tbl[0][4] = 3;
    nxt_tbl[1][0] = 2;
    nxt_tbl[3][0] = 4;
    nxt_tbl[4][4] = 5;
    nxt_tbl[5][0] = 5;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [3*N-1:0] vin);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (rst || !en) begin
        run_val[i] = 3'b111;
        run_len[i] = 1;
        m_filt[i]  = 3'b111;
        m_code[i]  = 2'b00;
        m_state[i] = 0;
        m_pend[i]  = 1'b0;
      end else begin
        if (m_pend[i]) begin
          int ns;
          ns = nxt_tbl[m_state[i]][m_filt[i]];
          if (m_state[i] == 1 && ns == 2) e.hse[i] = 1'b1;
          if (m_state[i] == 2 && ns == 0) e.hsx[i] = 1'b1;
          if (m_state[i] == 3 && ns == 4) e.lpe[i] = 1'b1;
          if (m_state[i] == 4 && ns == 5) e.ta[i]  = 1'b1;
          if (m_state[i] != 6 && ns == 6) e.err[i] = 1'b1;
          m_state[i] = ns;
          m_pend[i]  = 1'b0;
        end
        if (vin[3*i +: 3] == run_val[i]) run_len[i]++;
        else begin
          run_val[i] = vin[3*i +: 3];
          run_len[i] = 1;
        end
        if (run_len[i] >= D + 1 && run_val[i] != m_filt[i]) begin
          m_filt[i] = run_val[i];
          m_pend[i] = 1'b1;
          if (is_valid(run_val[i])) m_code[i] = code_of(run_val[i]);
        end
      end
      e.code[2*i +: 2]  = m_code[i];
      e.valid[i]        = is_valid(m_filt[i]);
      e.state[3*i +: 3] = 3'(m_state[i]);
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [3*N-1:0] vin);
    @(negedge Clk);
    Rst           = rst;
    CtrlDecoderEn = en;
    for (int i = 0; i < N; i++) begin
      LpA[i] = vin[3*i + 2];
      LpB[i] = vin[3*i + 1];
      LpC[i] = vin[3*i];
    end
    model_step(rst, en, vin);
  endtask

  task automatic hold(input logic rst, input logic en, input logic [3*N-1:0] vin, input int n);
    for (int k = 0; k < n; k++) cycle(rst, en, vin);
  endtask

  function automatic logic [3*N-1:0] vv(input logic [2:0] l0, input logic [2:0] l1, input logic [2:0] l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [2:0] pick();
    int k;
    logic [2:0] v;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    v = 3'b111;
      2, 3:    v = 3'b001;
      4, 5:    v = 3'b000;
      6, 7:    v = 3'b100;
      default: v = 3'($urandom_range(0, 7));
    endcase
    return v;
  endfunction

  // Monitor: the entry pushed at a negedge describes the outputs after the next posedge
  always @(posedge Clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("code",   32'(CtrlDecoderOut), 32'(mon_e.code));
      chk("valid",  32'(CtrlCodeValid),  32'(mon_e.valid));
      chk("state",  32'(LaneState),      32'(mon_e.state));
      chk("pulses", 32'({HsEntry, HsExit, LpEntry, TaRqst, SeqError}),
                    32'({mon_e.hse, mon_e.hsx, mon_e.lpe, mon_e.ta, mon_e.err}));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3*N-1:0] rv;
    int             hcnt[N];
    logic           r, en;
    model_init();
    hold(1'b1, 1'b1, vv(3'b111, 3'b111, 3'b111), 3);
    // HS entry/exit on trio 0
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b001, 3'b111, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b000, 3'b111, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // turnaround on trio 1
    hold(1'b0, 1'b1, vv(3'b111, 3'b100, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b000, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b100, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b000, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // glitch rejection on trio 0: 4 cycles rejected, 5 accepted
    hold(1'b0, 1'b1, vv(3'b001, 3'b111, 3'b111), 4);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 10);
    hold(1'b0, 1'b1, vv(3'b001, 3'b111, 3'b111), 5);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 10);
    // error path on trio 2
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b010), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b001), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // HS entry on trio 0 concurrently with the error path on trio 2
    hold(1'b0, 1'b1, vv(3'b001, 3'b111, 3'b010), 8);
    hold(1'b0, 1'b1, vv(3'b000, 3'b111, 3'b001), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // reset while in HS_ACTIVE
    hold(1'b0, 1'b1, vv(3'b001, 3'b111, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b000, 3'b111, 3'b111), 8);
    hold(1'b1, 1'b1, vv(3'b000, 3'b111, 3'b111), 1);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // enable drop while trio 1 is in LP_YIELD
    hold(1'b0, 1'b1, vv(3'b111, 3'b100, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b000, 3'b111), 8);
    hold(1'b0, 1'b0, vv(3'b111, 3'b000, 3'b111), 3);
    hold(1'b0, 1'b1, vv(3'b111, 3'b000, 3'b111), 8);
    hold(1'b0, 1'b1, vv(3'b111, 3'b111, 3'b111), 8);
    // randomized runs with occasional reset and enable drops
    rv = vv(3'b111, 3'b111, 3'b111);
    for (int i = 0; i < N; i++) hcnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hcnt[i] == 0) begin
          rv[3*i +: 3] = pick();
          hcnt[i] = $urandom_range(1, 9);
        end
        hcnt[i]--;
      end
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 99) != 0);
      cycle(r, en, rv);
    end
    @(posedge Clk);
    #3;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
